fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/fifo_uart_tx.sv | 106 ++++++++++
 tb/tb_fifo_uart_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared types and constants for the FIFO-fed UART transmitter
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int   DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - per-bit cycle counter that flags the last cycle of each serial bit
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a sync FIFO and serialises them as 8N1 or 8E1 frames
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   state_t     state, state_next;
   logic [7:0] shreg, shreg_next;
   logic [2:0] bit_idx, bit_idx_next;
   logic       parity, parity_next;
   logic       tx_next;
   logic       clear;
   logic       bit_end;

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         parity  <= 1'b0;
         tx      <= STOP_BIT;
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         bit_idx <= bit_idx_next;
         parity  <= parity_next;
         tx      <= tx_next;
      end
   end

   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      bit_idx_next = bit_idx;
      parity_next  = parity;
      clear        = 1'b0;
      tx_next      = STOP_BIT;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_next = FETCH;
         end
         FETCH: begin
            // parity is captured now because the shift register is consumed during DATA
            shreg_next  = fifo_data;
            parity_next = ^fifo_data;
            clear       = 1'b1;
            state_next  = START;
         end
         START: begin
            if (bit_end) begin
               state_next   = DATA;
               bit_idx_next = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_IDX) begin
                  state_next = PARITY_EN ? PARITY : STOP;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  shreg_next   = shreg >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_next = STOP;
         end
         STOP: begin
            if (bit_end) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // tx is registered, so it is chosen from the state being entered
      case (state_next)
         START:   tx_next = START_BIT;
         DATA:    tx_next = shreg_next[0];
         PARITY:  tx_next = parity_next;
         default: tx_next = STOP_BIT;
      endcase
   end

   assign fifo_rd    = (state == IDLE) && !fifo_empty && !rst;
   assign busy       = (state != IDLE);
   assign frame_done = (state == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - randomized scoreboard bench for fifo_uart_tx (plain and even-parity instances)
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   typedef struct {
      logic [7:0] data;
      int         pop_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] fempty = 2'b11;
   logic [7:0] fdata [2];
   logic [1:0] rd_w, tx_w, busy_w, done_w;

   int         cyc = 0;
   int         checks = 0;
   int         passes = 0;
   logic [7:0] src_q [2][$];
   exp_t       exp_q [2][$];
   int         pops [2];
   int         pushed [2];
   bit         hold_empty [2];
   bit         in_frame [2];
   bit         b2b [2];
   int         prev_done [2];
   logic [7:0] burst [8] = '{8'd12, 8'd22, 8'd16, 8'd4, 8'd25, 8'd36, 8'd17, 8'd28};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fempty[0]), .fifo_data(fdata[0]),
      .fifo_rd(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
   );

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_par (
      .clk(clk), .rst(rst), .fifo_empty(fempty[1]), .fifo_data(fdata[1]),
      .fifo_rd(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Line level of a given bit slot: start, 8 data bits LSB first, optional even parity, stop.
   function automatic logic frame_bit(input logic [7:0] d, input int slot, input bit par);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return d[slot-1];
      if (par && slot == 9) return logic'($countones(d) % 2);
      return 1'b1;
   endfunction

   task automatic push(input int id, input logic [7:0] b);
      src_q[id].push_back(b);
      pushed[id]++;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      int quiet = 0;
      while (quiet < 4 && n < max_cyc) begin
         @(negedge clk);
         #1;
         n++;
         if (src_q[0].size() == 0 && src_q[1].size() == 0 && exp_q[0].size() == 0 &&
             exp_q[1].size() == 0 && !in_frame[0] && !in_frame[1] && busy_w == 2'b00)
            quiet++;
         else
            quiet = 0;
      end
      check("idle_reached", 32'(quiet >= 4), 1);
   endtask

   task automatic wait_pop(input int id, input int target, input int max_cyc);
      int n = 0;
      while (pops[id] < target && n < max_cyc) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("pop_seen", 32'(pops[id] >= target), 1);
   endtask

   // Upstream FIFO model: a pop seen in cycle N presents data during cycle N+1.
   initial begin : fifo_model
      logic rd_seen [2];
      int   rd_cyc [2];
      forever begin
         @(negedge clk);
         for (int id = 0; id < 2; id++) begin
            rd_seen[id] = rd_w[id];
            rd_cyc[id]  = cyc;
            if (rd_w[id]) begin
               pops[id]++;
               check($sformatf("rd_legal%0d", id), {30'd0, fempty[id], rst}, 0);
            end
         end
         @(posedge clk);
         #1;
         for (int id = 0; id < 2; id++) begin
            if (rd_seen[id] && src_q[id].size() > 0) begin
               fdata[id] = src_q[id].pop_front();
               exp_q[id].push_back('{data: fdata[id], pop_cyc: rd_cyc[id]});
            end
            fempty[id] = (src_q[id].size() == 0) || hold_empty[id];
         end
      end
   end

   initial begin : monitor
      exp_t cur [2];
      int   pos [2];
      bit   after [2];
      int   flen;
      forever begin
         @(negedge clk);
         for (int id = 0; id < 2; id++) begin
            flen = (10 + id) * CPB;
            if (rst) begin
               in_frame[id] = 1'b0;
               after[id]    = 1'b0;
               exp_q[id].delete();
            end else if (in_frame[id]) begin
               check($sformatf("line%0d", id), {29'd0, tx_w[id], busy_w[id], done_w[id]},
                     {29'd0, frame_bit(cur[id].data, pos[id] / CPB, id == 1), 1'b1, pos[id] == flen - 1});
               pos[id]++;
               if (pos[id] == flen) begin
                  in_frame[id]  = 1'b0;
                  after[id]     = 1'b1;
                  prev_done[id] = cyc;
               end
            end else begin
               if (after[id]) begin
                  check($sformatf("busy_fall%0d", id), {31'd0, busy_w[id]}, 0);
                  after[id] = 1'b0;
               end
               if (tx_w[id] == 1'b0) begin
                  check($sformatf("exp_present%0d", id), 32'(exp_q[id].size() > 0), 1);
                  if (exp_q[id].size() > 0) begin
                     cur[id] = exp_q[id].pop_front();
                     check($sformatf("start_lat%0d", id), cyc, cur[id].pop_cyc + 2);
                     if (b2b[id] && prev_done[id] >= 0)
                        check($sformatf("gap%0d", id), cyc - prev_done[id], 3);
                     check($sformatf("line%0d", id), {29'd0, tx_w[id], busy_w[id], done_w[id]}, 32'b010);
                     pos[id]      = 1;
                     in_frame[id] = 1'b1;
                  end
               end else begin
                  check($sformatf("idle_done%0d", id), {31'd0, done_w[id]}, 0);
               end
            end
         end
      end
   end

   initial begin : stim
      int p0;
      int id;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         check($sformatf("rst_out%0d", i), {28'd0, tx_w[i], busy_w[i], done_w[i], rd_w[i]}, 32'b1000);
      @(posedge clk);
      #1 rst = 1'b0;

      push(0, 8'h0C);
      wait_idle(300);
      check("pops_single", pops[0], 1);

      push(1, 8'h07);
      wait_idle(300);
      check("pops_parity", pops[1], 1);

      prev_done[0] = -1;
      b2b[0] = 1'b1;
      foreach (burst[i]) push(0, burst[i]);
      wait_idle(1000);
      b2b[0] = 1'b0;
      check("pops_burst", pops[0], 9);

      for (int n = 0; n < 24; n++) begin
         id = int'($urandom_range(0, 1));
         push(id, 8'($urandom));
         repeat ($urandom_range(0, 60)) @(posedge clk);
         #1;
      end
      wait_idle(4000);

      repeat (100) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            check($sformatf("empty_idle%0d", i), {29'd0, rd_w[i], tx_w[i], busy_w[i]}, 32'b010);
      end

      // empty flag rises while START is on the line
      p0 = pops[0];
      push(0, 8'hA5);
      push(0, 8'h3C);
      wait_pop(0, p0 + 1, 50);
      repeat (3) @(posedge clk);
      #1 hold_empty[0] = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check("no_pop_held", pops[0], p0 + 1);
      hold_empty[0] = 1'b0;
      wait_idle(300);
      check("pop_after_hold", pops[0], p0 + 2);

      // reset during DATA bit 3: first byte is dropped, second is sent whole
      p0 = pops[0];
      push(0, 8'hF0);
      push(0, 8'h5A);
      wait_pop(0, p0 + 1, 50);
      repeat (19) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid", {28'd0, tx_w[0], busy_w[0], done_w[0], rd_w[0]}, 32'b1000);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_idle(300);
      check("pop_after_rst", pops[0], p0 + 2);

      for (int i = 0; i < 2; i++) check($sformatf("pops_total%0d", i), pops[i], pushed[i]);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
      $fatal(1);
   end

endmodule
